// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: FSM state
// encoding and the clock-to-baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit, truncated.
  function automatic int bit_div(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to a
// parameterised value so an idle line does not look like an edge after reset.
module uart_sync #(
  parameter logic RstVal = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= RstVal;
      r_sync <= RstVal;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 8 data bits LSB first, Stop stop bits,
// centre-of-bit sampling, one-cycle valid strobe with framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Clock = 50_000_000,
  parameter int Baud  = 9600,
  parameter int Stop  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV  = bit_div(Clock, Baud);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
  localparam logic [1:0]    STOP_LAST = 2'(Stop - 1);

  if (DIV < 16) begin : g_bad_div
    $fatal(1, "uart_rx: Clock/Baud = %0d, must be >= 16", DIV);
  end
  if (Stop < 1 || Stop > 4) begin : g_bad_stop
    $fatal(1, "uart_rx: Stop = %0d, must be 1..4", Stop);
  end

  logic w_rxd_s;

  uart_sync #(.RstVal(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (rxd),
    .o_q   (w_rxd_s)
  );

  uart_state_e r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [1:0]    r_sbit, w_sbit_next;
  logic [7:0]    r_shreg, w_shreg_next;
  logic          r_err, w_err_next;
  logic          w_done;
  logic          w_full_tick;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_full_tick = (r_cnt == FULL_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_sbit_next  = r_sbit;
    w_shreg_next = r_shreg;
    w_err_next   = r_err;
    w_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rxd_s) begin
          w_state_next = START;
          w_cnt_next   = '0;
        end
      end

      START: begin
        if (r_cnt == HALF_LAST) begin
          // A start bit that is high again at its centre was a glitch.
          w_cnt_next = '0;
          if (w_rxd_s) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = DATA;
            w_bit_next   = '0;
            w_err_next   = 1'b0;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      DATA: begin
        if (w_full_tick) begin
          w_cnt_next            = '0;
          w_shreg_next[r_bit]   = w_rxd_s;
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
            w_bit_next   = '0;
            w_sbit_next  = '0;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      STOP: begin
        if (w_full_tick) begin
          w_cnt_next = '0;
          if (!w_rxd_s) w_err_next = 1'b1;
          // Leave at the centre of the last stop bit so a following start
          // bit from a slightly fast sender is still caught.
          if (r_sbit == STOP_LAST) begin
            w_state_next = IDLE;
            w_sbit_next  = '0;
            w_done       = 1'b1;
          end else begin
            w_sbit_next = r_sbit + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sbit  <= '0;
      r_shreg <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_sbit  <= w_sbit_next;
      r_shreg <= w_shreg_next;
      r_err   <= w_err_next;
      r_valid <= w_done;
      if (w_done) begin
        r_data <= w_shreg_next;
        r_ferr <= w_err_next;
      end
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign ferr  = r_ferr;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three receivers (Stop 2, 4, 1) fed by a
// hand-driven serial line, checked through an expected/observed scoreboard.
module tb_uart_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 781_250;
  localparam int DIV    = CLK_HZ / BAUD;                 // 64
  localparam int LAT0   = 2 + DIV / 2 + (8 + 2) * DIV + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       ferr;
    longint     cyc;
  } rec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_a [3];
  logic [7:0] dat   [3];
  logic       vld   [3];
  logic       fe    [3];
  logic       bsy   [3];

  longint cyc = 0;
  longint last_t0 = 0;
  int     n_vec = 0;
  int     n_err = 0;
  rec_t   exp_q [$];
  rec_t   obs_q [$];

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  uart_rx #(.Clock(CLK_HZ), .Baud(BAUD), .Stop(2)) u_rx2 (
    .clock (clock), .reset (reset), .rxd (rxd_a[0]),
    .data  (dat[0]), .valid (vld[0]), .ferr (fe[0]), .busy (bsy[0])
  );

  uart_rx #(.Clock(CLK_HZ), .Baud(BAUD), .Stop(4)) u_rx4 (
    .clock (clock), .reset (reset), .rxd (rxd_a[1]),
    .data  (dat[1]), .valid (vld[1]), .ferr (fe[1]), .busy (bsy[1])
  );

  uart_rx #(.Clock(CLK_HZ), .Baud(BAUD), .Stop(1)) u_rx1 (
    .clock (clock), .reset (reset), .rxd (rxd_a[2]),
    .data  (dat[2]), .valid (vld[2]), .ferr (fe[2]), .busy (bsy[2])
  );

  // Every valid strobe is captured with its cycle number.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] === 1'b1)
        obs_q.push_back('{idx: k, data: dat[k], ferr: fe[k], cyc: cyc});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input int k, input logic [7:0] b, input int nstop,
                            input int bitlen, input logic stop_low);
    exp_q.push_back('{idx: k, data: b, ferr: stop_low, cyc: 0});
    last_t0  = cyc;
    rxd_a[k] = 1'b0;
    cycles(bitlen);
    for (int i = 0; i < 8; i++) begin
      rxd_a[k] = b[i];
      cycles(bitlen);
    end
    for (int i = 0; i < nstop; i++) begin
      rxd_a[k] = ~stop_low;
      cycles(bitlen);
    end
    rxd_a[k] = 1'b1;
  endtask

  task automatic drain(input string tag);
    rec_t e;
    rec_t o;
    cycles(2 * DIV);
    check({tag, " valid count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, " dut"},  o.idx,  e.idx);
      check({tag, " data"}, o.data, e.data);
      check({tag, " ferr"}, o.ferr, e.ferr);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    longint lat;
    logic [7:0] b2b [6];
    b2b = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h81, 8'h7E};
    for (int k = 0; k < 3; k++) rxd_a[k] = 1'b1;

    // Reset state
    cycles(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset data[%0d]", k),  dat[k], 8'h00);
      check($sformatf("reset valid[%0d]", k), vld[k], 1'b0);
      check($sformatf("reset ferr[%0d]", k),  fe[k],  1'b0);
      check($sformatf("reset busy[%0d]", k),  bsy[k], 1'b0);
    end
    reset = 1'b0;
    cycles(4);

    // 1: single frame, Stop 2, latency from falling edge
    send_frame(0, 8'hA5, 2, DIV, 1'b0);
    lat = (obs_q.size() != 0) ? obs_q[0].cyc - last_t0 : -1;
    check("t1 latency", (lat >= LAT0 - 1 && lat <= LAT0 + 1) ? LAT0 : 32'(lat), LAT0);
    drain("t1");

    // 2: Stop 4, repeated 8'h5A back to back
    for (int i = 0; i < 4; i++) send_frame(1, 8'h5A, 4, DIV, 1'b0);
    drain("t2");

    // 3: short low glitch on idle line
    last_t0 = cyc;
    rxd_a[0] = 1'b0;
    cycles(2);
    check("t3 busy before start", bsy[0], 1'b0);
    cycles(8);
    check("t3 busy in start", bsy[0], 1'b1);
    cycles(10);
    check("t3 busy end of pulse", bsy[0], 1'b1);
    rxd_a[0] = 1'b1;
    cycles(20);
    check("t3 busy after reject", bsy[0], 1'b0);
    drain("t3");

    // 4: stop bits forced low, then a clean frame
    send_frame(0, 8'h3C, 2, DIV, 1'b1);
    cycles(2 * DIV);
    send_frame(0, 8'h81, 2, DIV, 1'b0);
    drain("t4");

    // 5: reset in the middle of data bit 4, then a good frame
    rxd_a[0] = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 4; i++) begin
      rxd_a[0] = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      cycles(DIV);
    end
    rxd_a[0] = 1'b0;
    cycles(DIV / 2);
    check("t5 busy before reset", bsy[0], 1'b1);
    reset    = 1'b1;
    rxd_a[0] = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("t5 busy after reset",  bsy[0], 1'b0);
    check("t5 valid after reset", vld[0], 1'b0);
    check("t5 data after reset",  dat[0], 8'h00);
    drain("t5 abort");
    send_frame(0, 8'hA5, 2, DIV, 1'b0);
    drain("t5");

    // 6: fast sender, Stop 1, back to back
    for (int i = 0; i < 6; i++) send_frame(2, b2b[i], 1, DIV - 1, 1'b0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
